// File: rtl/nn_f2_pkg.sv
// Shared constants and state encoding for the nn_f2 frame loader.
package nn_f2_pkg;

    localparam int IMG_BITS    = 288;
    localparam int FLT_BITS    = 18;
    localparam int N_FLT       = 4;
    localparam int IMG_BYTES   = 36;
    localparam int FLT_BYTES   = 9;
    localparam int FRAME_BYTES = 45;
    localparam int CNT_W       = 6;
    localparam int LAT_W       = 8;

    typedef enum logic [1:0] {
        LOAD_IMG,
        LOAD_FLT,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/nn_f2_byte_reg.sv
// Byte-addressable operand register: one byte lane written per enabled cycle,
// every other lane holds. Cleared only by reset.
module nn_f2_byte_reg #(
    parameter int NBYTES = 36,
    parameter int IDX_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [7:0]            wr_data,
    output logic [NBYTES*8-1:0]   q
);

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            logic [7:0] lane_reg;

            // Capture the incoming byte only when this lane is addressed.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg <= '0;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    lane_reg <= wr_data;
                end
            end

            assign q[gi*8 +: 8] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/nn_f2_frame_loader.sv
// Byte-stream front end for the nn_f2 convolution datapath: assembles a
// 45-byte frame into image/filter operand buses, holds them for LATENCY
// cycles, then presents out_valid until acknowledged.
module nn_f2_frame_loader
    import nn_f2_pkg::*;
#(
    parameter int LATENCY = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic [IMG_BITS-1:0] img,
    output logic [FLT_BITS-1:0] filter1,
    output logic [FLT_BITS-1:0] filter2,
    output logic [FLT_BITS-1:0] filter3,
    output logic [FLT_BITS-1:0] filter4,
    output logic                out_valid,
    input  logic                out_ack,
    output logic                busy,
    output logic                frame_err
);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [LAT_W-1:0]   lat_reg, lat_next;
    logic               s_ready_reg;
    logic               out_valid_reg;
    logic               frame_err_reg, frame_err_next;

    logic               accept;
    logic               img_we;
    logic               flt_we;
    logic [CNT_W-1:0]   flt_idx;
    logic [FLT_BYTES*8-1:0] flt_q;

    // s_ready is only ever high in the load states, so this is the transfer.
    assign accept  = s_valid && s_ready_reg;
    assign img_we  = accept && (cnt_reg < CNT_W'(IMG_BYTES));
    assign flt_we  = accept && (cnt_reg >= CNT_W'(IMG_BYTES));
    assign flt_idx = cnt_reg - CNT_W'(IMG_BYTES);

    // Next-state, byte counter, latency counter and framing-error decode.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        lat_next       = lat_reg;
        frame_err_next = 1'b0;
        case (state_reg)
            LOAD_IMG, LOAD_FLT: begin
                if (accept) begin
                    if (cnt_reg == CNT_W'(FRAME_BYTES - 1)) begin
                        // Final byte always completes the frame; a missing
                        // s_last is flagged but not fatal.
                        state_next     = WAIT;
                        cnt_next       = '0;
                        lat_next       = '0;
                        frame_err_next = !s_last;
                    end else if (s_last) begin
                        // Short frame: byte is kept, frame is abandoned.
                        state_next     = LOAD_IMG;
                        cnt_next       = '0;
                        frame_err_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                        if (cnt_reg == CNT_W'(IMG_BYTES - 1)) begin
                            state_next = LOAD_FLT;
                        end
                    end
                end
            end
            WAIT: begin
                if (lat_reg == LAT_W'(LATENCY - 1)) begin
                    state_next = DONE;
                end else begin
                    lat_next = lat_reg + 1'b1;
                end
            end
            DONE: begin
                if (out_ack) begin
                    state_next = LOAD_IMG;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = LOAD_IMG;
                cnt_next   = '0;
            end
        endcase
    end

    // State registers; handshake outputs are registered from next-state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= LOAD_IMG;
            cnt_reg       <= '0;
            lat_reg       <= '0;
            s_ready_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            lat_reg       <= lat_next;
            s_ready_reg   <= (state_next == LOAD_IMG) || (state_next == LOAD_FLT);
            out_valid_reg <= (state_next == DONE);
            frame_err_reg <= frame_err_next;
        end
    end

    nn_f2_byte_reg #(
        .NBYTES (IMG_BYTES),
        .IDX_W  (CNT_W)
    ) u_img_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (img_we),
        .wr_idx  (cnt_reg),
        .wr_data (s_data),
        .q       (img)
    );

    nn_f2_byte_reg #(
        .NBYTES (FLT_BYTES),
        .IDX_W  (CNT_W)
    ) u_flt_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (flt_we),
        .wr_idx  (flt_idx),
        .wr_data (s_data),
        .q       (flt_q)
    );

    assign filter1   = flt_q[0*FLT_BITS +: FLT_BITS];
    assign filter2   = flt_q[1*FLT_BITS +: FLT_BITS];
    assign filter3   = flt_q[2*FLT_BITS +: FLT_BITS];
    assign filter4   = flt_q[3*FLT_BITS +: FLT_BITS];

    assign s_ready   = s_ready_reg;
    assign out_valid = out_valid_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg == WAIT) || (state_reg == DONE);

endmodule

// File: tb/tb_nn_f2_frame_loader.sv
// Scoreboard bench for nn_f2_frame_loader: the driver pushes expected
// operands / edges, an independent negedge monitor pops and compares.
module tb_nn_f2_frame_loader;

    localparam int L = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   s_data = 8'h00;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic         s_ready;
    logic [287:0] img;
    logic [17:0]  filter1, filter2, filter3, filter4;
    logic         out_valid;
    logic         out_ack = 1'b0;
    logic         busy;
    logic         frame_err;

    nn_f2_frame_loader #(.LATENCY(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .img       (img),
        .filter1   (filter1),
        .filter2   (filter2),
        .filter3   (filter3),
        .filter4   (filter4),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [287:0] img;
        logic [71:0]  flt;
        int           edge_e;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops expectations when the DUT presents out_valid / frame_err.
    logic prev_ov = 1'b0;
    logic prev_fe = 1'b0;
    int   run = 0;
    int   last_run = -1;
    int   rises = 0;
    always @(negedge clk) begin
        exp_t x;
        int   e;
        if (frame_err) begin
            chk("frame_err_width", prev_fe, 1'b0);
            if (err_q.size() == 0) begin
                chk("frame_err_unexpected", 1, 0);
            end else begin
                e = err_q.pop_front();
                chk("frame_err_edge", cyc, e);
            end
        end
        if (out_valid && !prev_ov) begin
            rises++;
            if (exp_q.size() == 0) begin
                chk("out_valid_unexpected", 1, 0);
            end else begin
                x = exp_q.pop_front();
                chk("result_edge", cyc, x.edge_e);
                chk("result_img", img, x.img);
                chk("result_flt", {filter4, filter3, filter2, filter1}, x.flt);
            end
        end
        if (out_valid) begin
            run++;
        end else if (prev_ov) begin
            last_run = run;
            run = 0;
        end
        prev_ov = out_valid;
        prev_fe = frame_err;
    end

    // Offer one byte (called at a negedge); returns the accepting edge number.
    task automatic send_byte(input logic [7:0] d, input logic last, input bit gap,
                             input bit experr, output int edge_n);
        int waited;
        int n;
        n = gap ? int'($urandom_range(0, 2)) : 0;
        repeat (n) begin
            s_valid = 1'b0;
            s_data  = 8'hEE;
            s_last  = 1'b1;
            @(negedge clk);
        end
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        waited  = 0;
        while (!s_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL s_ready_timeout: got 0 want 1 (cycle %0d)", cyc);
            $fatal(1, "stream stalled");
        end
        edge_n = cyc + 1;
        if (experr) err_q.push_back(edge_n);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b [45], input int n, input int last_idx,
                              input bit gap, input bit push,
                              output int e_first, output int e_last);
        exp_t x;
        int   e;
        bit   experr;
        e_first = 0;
        e_last  = 0;
        for (int k = 0; k < n; k++) begin
            experr = ((k == last_idx) && (k < 44)) || ((k == 44) && (last_idx != 44));
            send_byte(b[k], (k == last_idx), gap, experr, e);
            if (k == 0) e_first = e;
            e_last = e;
        end
        if (push && n == 45) begin
            for (int k = 0; k < 36; k++) x.img[8*k +: 8] = b[k];
            for (int j = 0; j < 9; j++)  x.flt[8*j +: 8] = b[36 + j];
            x.edge_e = e_last + L;
            exp_q.push_back(x);
        end
    endtask

    // Wait for out_valid (bounded), optionally offering junk, then ack after hold cycles.
    task automatic wait_done(input bit junk, input int hold);
        int w;
        w = 0;
        if (junk) begin
            s_data  = 8'hFF;
            s_last  = 1'b0;
            s_valid = 1'b1;
        end else begin
            s_valid = 1'b0;
        end
        while (!out_valid && w < 500) begin
            @(negedge clk);
            w++;
        end
        s_valid = 1'b0;
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL out_valid_timeout: got 0 want 1 (cycle %0d)", cyc);
            $fatal(1, "out_valid never rose");
        end
        repeat (hold) @(negedge clk);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
    endtask

    task automatic check_nominal();
        chk("nom_img_lo",  img[7:0], 8'h00);
        chk("nom_img_hi",  img[287:280], 8'h23);
        chk("nom_filter1", filter1, 18'h2A1A0);
        chk("nom_filter2", filter2, 18'h128E8);
        chk("nom_filter3", filter3, 18'h26A5A);
        chk("nom_filter4", filter4, 18'h2A29E);
    endtask

    logic [7:0] nom [45];
    logic [7:0] fb  [45];
    logic [7:0] fb2 [45];
    int ef, el, ea, eb, r0;

    initial begin
        for (int k = 0; k < 36; k++) nom[k] = 8'(k);
        for (int j = 0; j < 9; j++)  nom[36 + j] = 8'(8'hA0 + j);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_s_ready",   s_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy",      busy, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_img",       img, '0);
        chk("rst_flt",       {filter4, filter3, filter2, filter1}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_s_ready", s_ready, 1'b1);

        // Nominal frame
        send_frame(nom, 45, 44, 1'b0, 1'b1, ef, el);
        s_valid = 1'b0;
        chk("wait_s_ready", s_ready, 1'b0);
        chk("wait_busy",    busy, 1'b1);
        wait_done(1'b0, 3);
        chk("ack_out_valid", out_valid, 1'b0);
        chk("ack_s_ready",   s_ready, 1'b1);
        chk("ack_busy",      busy, 1'b0);
        check_nominal();

        // Early s_last on byte 20
        for (int k = 0; k < 45; k++) fb[k] = 8'(k) ^ 8'h5A;
        r0 = rises;
        send_frame(fb, 21, 20, 1'b0, 1'b0, ef, el);
        s_valid = 1'b0;
        repeat (L + 5) @(negedge clk);
        chk("early_no_out_valid", rises, r0);
        chk("early_busy",    busy, 1'b0);
        chk("early_s_ready", s_ready, 1'b1);
        chk("early_img_b20", img[167:160], 8'(20) ^ 8'h5A);

        // Backpressure with gaps, junk offered while waiting
        send_frame(nom, 45, 44, 1'b1, 1'b1, ef, el);
        wait_done(1'b1, 2);
        check_nominal();

        // Missing s_last on byte 44
        for (int k = 0; k < 45; k++) fb[k] = 8'(k * 3 + 1);
        send_frame(fb, 45, -1, 1'b0, 1'b1, ef, el);
        s_valid = 1'b0;
        wait_done(1'b0, 0);

        // Ack held high across DONE; back-to-back second frame
        for (int k = 0; k < 45; k++) fb[k]  = 8'(k + 8'h40);
        for (int k = 0; k < 45; k++) fb2[k] = 8'(255 - k);
        last_run = -1;
        out_ack = 1'b1;
        send_frame(fb, 45, 44, 1'b0, 1'b1, ef, ea);
        send_frame(fb2, 45, 44, 1'b0, 1'b1, eb, el);
        out_ack = 1'b0;
        chk("b2b_first_accept", eb, ea + L + 2);
        chk("ack_held_ov_cycles", last_run, 1);
        wait_done(1'b0, 1);

        // Reset mid-WAIT
        for (int k = 0; k < 45; k++) fb[k] = 8'(k) ^ 8'h3C;
        send_frame(fb, 45, 44, 1'b0, 1'b0, ef, el);
        s_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("midwait_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mrst_img",       img, '0);
        chk("mrst_flt",       {filter4, filter3, filter2, filter1}, '0);
        chk("mrst_busy",      busy, 1'b0);
        chk("mrst_out_valid", out_valid, 1'b0);
        chk("mrst_s_ready",   s_ready, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrel_s_ready", s_ready, 1'b1);
        chk("mrel_busy",    busy, 1'b0);
        repeat (L + 4) @(negedge clk);

        chk("exp_q_drained", exp_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
